// File: rtl/tf_fetch_ctrl.sv
// tf_fetch_ctrl -- twiddle-factor fetch controller.
//
// Reads a run of consecutive twiddle ROM words, starting at base_addr and
// wrapping modulo 2^ADDR_W. Each word is passed through a 2-entry output FIFO
// to the TF delay pipeline. The ROM has a fixed read latency of one cycle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse; honoured only in IDLE
//   base_addr     first ROM word of the run
//   num_words     words in the run (0 means 2^ADDR_W)
//   modulus_in    modulus for the run, latched on start
//   rom_rd_en     ROM read strobe
//   rom_rd_addr   ROM read address
//   rom_rd_data   16 TFs, valid one cycle after rom_rd_en
//   tf_out        FIFO head (TF0 in the lowest slice)
//   modulus_out   latched modulus
//   tf_valid      tf_out holds a word
//   tf_ready      consumer accepts the word
//   busy          run in progress (FETCH or DRAIN)
//   done          one-cycle pulse when the last word transfers
//   stall_cnt     (only with TF_FETCH_STALL_CNT_EN) cycles with tf_valid high
//                 and tf_ready low, saturating at 0xFFFF
//
// Handshake: a word transfers on every cycle where tf_valid and tf_ready are
// both high; while tf_valid is high and tf_ready is low, tf_out holds steady.
//
// Optional feature macro: TF_FETCH_STALL_CNT_EN.

`ifndef D_width
`define D_width 16
`endif

module tf_fetch_ctrl #(
   parameter int D_WIDTH = `D_width,
   parameter int ADDR_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      base_addr,
   input  logic [ADDR_W-1:0]      num_words,
   input  logic [D_WIDTH-1:0]     modulus_in,
   output logic                   rom_rd_en,
   output logic [ADDR_W-1:0]      rom_rd_addr,
   input  logic [16*D_WIDTH-1:0]  rom_rd_data,
   output logic [16*D_WIDTH-1:0]  tf_out,
   output logic [D_WIDTH-1:0]     modulus_out,
   output logic                   tf_valid,
   input  logic                   tf_ready,
   output logic                   busy,
   output logic                   done
`ifdef TF_FETCH_STALL_CNT_EN
   ,
   output logic [15:0]            stall_cnt
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   // Counters are one bit wider than the address so a full 2^ADDR_W run fits.
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] ONE = CW'(1);

   logic [1:0]             state_q, state_d;
   logic [ADDR_W-1:0]      base_q;
   logic [CW-1:0]          total_q;
   logic [CW-1:0]          issue_cnt_q;
   logic [CW-1:0]          accept_cnt_q;
   logic [D_WIDTH-1:0]     modulus_q;
   logic                   inflight_q;
   logic [16*D_WIDTH-1:0]  fifo_mem_q [2];
   logic                   wr_ptr_q;
   logic                   rd_ptr_q;
   logic [1:0]             count_q;

   logic                   accept_start;
   logic                   push;
   logic                   pop;
   logic [1:0]             occ_after_pop;
   logic                   room;
   logic                   last_issue;
   logic                   last_accept;

   assign accept_start = (state_q == S_IDLE) && start;
   assign tf_valid     = (count_q != 2'd0);
   assign tf_out       = fifo_mem_q[rd_ptr_q];
   assign pop          = tf_valid && tf_ready;
   // The read issued last cycle lands in the FIFO at this edge.
   assign push         = inflight_q;

   // A word leaving this cycle frees its slot, so a read may issue in the
   // same cycle; this keeps one word per cycle with tf_ready held high.
   assign occ_after_pop = count_q - {1'b0, pop};
   assign room          = ({1'b0, occ_after_pop} + {2'b00, inflight_q}) < 3'd2;

   assign rom_rd_en   = (state_q == S_FETCH) && room;
   assign rom_rd_addr = base_q + issue_cnt_q[ADDR_W-1:0];

   assign last_issue  = rom_rd_en && (issue_cnt_q == total_q - ONE);
   assign last_accept = pop && (accept_cnt_q == total_q - ONE);

   assign busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign done        = (state_q == S_DRAIN) && last_accept;
   assign modulus_out = modulus_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)       state_d = S_FETCH;
         S_FETCH: if (last_issue)  state_d = S_DRAIN;
         S_DRAIN: if (last_accept) state_d = S_IDLE;
         default:                  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         total_q      <= '0;
         issue_cnt_q  <= '0;
         accept_cnt_q <= '0;
         modulus_q    <= '0;
         inflight_q   <= 1'b0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         for (int i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= rom_rd_en;

         if (accept_start) begin
            base_q       <= base_addr;
            total_q      <= (num_words == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                              : {1'b0, num_words};
            modulus_q    <= modulus_in;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
         end

         if (rom_rd_en) issue_cnt_q  <= issue_cnt_q + ONE;
         if (pop)       accept_cnt_q <= accept_cnt_q + ONE;

         if (push) begin
            fifo_mem_q[wr_ptr_q] <= rom_rd_data;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;

         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef TF_FETCH_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || accept_start) begin
         stall_cnt <= 16'd0;
      end else if (tf_valid && !tf_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tf_fetch_ctrl.sv
// tb_tf_fetch_ctrl -- directed bench for tf_fetch_ctrl (D_WIDTH=16, ADDR_W=8).
// A behavioural ROM returns a known pattern per address one cycle after each
// read; every run is stepped cycle by cycle from one initial block.

module tb_tf_fetch_ctrl;

   localparam int DW = 16;
   localparam int AW = 8;
   localparam int WW = 16 * DW;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [AW-1:0]  base_addr = '0;
   logic [AW-1:0]  num_words = '0;
   logic [DW-1:0]  modulus_in = '0;
   logic           rom_rd_en;
   logic [AW-1:0]  rom_rd_addr;
   logic [WW-1:0]  rom_rd_data = '0;
   logic [WW-1:0]  tf_out;
   logic [DW-1:0]  modulus_out;
   logic           tf_valid;
   logic           tf_ready = 1'b1;
   logic           busy;
   logic           done;
`ifdef TF_FETCH_STALL_CNT_EN
   logic [15:0]    stall_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int first_rd, first_val, done_cyc, done_cnt;

   tf_fetch_ctrl #(.D_WIDTH(DW), .ADDR_W(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .num_words   (num_words),
      .modulus_in  (modulus_in),
      .rom_rd_en   (rom_rd_en),
      .rom_rd_addr (rom_rd_addr),
      .rom_rd_data (rom_rd_data),
      .tf_out      (tf_out),
      .modulus_out (modulus_out),
      .tf_valid    (tf_valid),
      .tf_ready    (tf_ready),
      .busy        (busy),
      .done        (done)
`ifdef TF_FETCH_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Lane i of word a holds {a, i, 4'hA} ^ 16'h5A00.
   function automatic logic [WW-1:0] rom_word(input logic [AW-1:0] a);
      logic [WW-1:0] w;
      logic [3:0]    li;
      w = '0;
      for (int i = 0; i < 16; i++) begin
         li = i[3:0];
         w[i*DW +: DW] = {a, li, 4'hA} ^ 16'h5A00;
      end
      return w;
   endfunction

   // Behavioural ROM: one-cycle read latency.
   always @(posedge clk) begin
      if (rom_rd_en) rom_rd_data <= rom_word(rom_rd_addr);
   end

   task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One run: start at cycle 0, then step and check every cycle until all
   // words are accepted, the budget expires, or abort_after words are taken.
   task automatic run(input logic [AW-1:0] base, input int n, input logic [DW-1:0] modv,
                      input int stall_at, input int stall_len, input int abort_after,
                      input bit inject);
      int issued, acc, cyc;
      logic [AW-1:0] ea;
      logic popped;
      first_rd = -1; first_val = -1; done_cyc = -1; done_cnt = 0;
      base_addr  = base;
      num_words  = n[AW-1:0];
      modulus_in = modv;
      tf_ready   = 1'b1;
      start      = 1'b1;
      @(posedge clk); #1;
      issued = 0; acc = 0; cyc = 1;
      while (acc < n && cyc < n + 60 && !(abort_after >= 0 && acc == abort_after)) begin
         start = inject && (cyc == 5);
         if (start) begin
            base_addr  = base + 8'h40;
            modulus_in = ~modv;
            num_words  = 8'd3;
         end
         tf_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         #1;
         chk("busy_in_run", busy, 1'b1);
         chk("modulus_out", modulus_out, modv);
         if (rom_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            ea = base + issued[AW-1:0];
            chk("rd_addr", rom_rd_addr, ea);
            chk("rd_within_run", issued < n, 1'b1);
            issued++;
         end
         popped = 1'b0;
         if (tf_valid) begin
            if (first_val < 0) first_val = cyc;
            ea = base + acc[AW-1:0];
            chk("tf_out", tf_out, rom_word(ea));
            if (tf_ready) begin
               acc++;
               popped = 1'b1;
            end
         end
         chk("outstanding_le2", (issued - acc) <= 2, 1'b1);
         chk("done", done, popped && (acc == n));
         if (done) begin
            done_cyc = cyc;
            done_cnt++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      tf_ready = 1'b1;
      if (abort_after < 0) chk("run_complete", acc, n);
   endtask

   task automatic post_idle(input logic [DW-1:0] modv, input logic [15:0] exp_stall);
      #1;
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_valid", tf_valid, 1'b0);
      chk("idle_rd_en", rom_rd_en, 1'b0);
      chk("idle_modulus", modulus_out, modv);
`ifdef TF_FETCH_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, exp_stall);
`else
      if (exp_stall != 16'hFFFF) chk("idle_valid_again", tf_valid, 1'b0);
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd_en", rom_rd_en, 1'b0);
      chk("rst_rd_addr", rom_rd_addr, 8'h00);
      chk("rst_valid", tf_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_tf_out", tf_out, '0);
      chk("rst_modulus", modulus_out, 16'h0000);
      // Start in the first cycle after reset release
      rst = 1'b0;

      // Basic run: reads 0x10..0x13 at cycles 1..4, valid 3..6, done at 6
      run(8'h10, 4, 16'h1234, 1000, 0, -1, 1'b0);
      chk("basic_first_rd", first_rd, 1);
      chk("basic_first_valid", first_val, 3);
      chk("basic_done_cyc", done_cyc, 6);
      chk("basic_done_cnt", done_cnt, 1);
      post_idle(16'h1234, 16'd0);

      // Wrap-around: 0xFE, 0xFF, 0x00, 0x01
      run(8'hFE, 4, 16'h0101, 1000, 0, -1, 1'b0);
      chk("wrap_done_cyc", done_cyc, 6);
      post_idle(16'h0101, 16'd0);

      // Backpressure: tf_ready low for cycles 4..8
      run(8'h20, 8, 16'hBEEF, 4, 5, -1, 1'b0);
      chk("stall_done_cnt", done_cnt, 1);
      chk("stall_done_cyc", done_cyc, 15);
      post_idle(16'hBEEF, 16'd5);

      // Start during a busy run is ignored
      run(8'h30, 8, 16'h0F0F, 1000, 0, -1, 1'b1);
      chk("ignored_done_cyc", done_cyc, 10);
      post_idle(16'h0F0F, 16'd0);
      chk("ignored_no_new_run", busy, 1'b0);

      // Reset after 2 of 8 words
      run(8'h50, 8, 16'h7777, 1000, 0, 2, 1'b0);
      rst = 1'b1;
      #1;
      chk("abort_no_done_in_rst", done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_valid", tf_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_rd_en", rom_rd_en, 1'b0);
      chk("abort_tf_out", tf_out, '0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #2;
         chk("abort_inflight_dropped", tf_valid, 1'b0);
         chk("abort_done_later", done, 1'b0);
      end

      // Single-word run after abort
      run(8'h60, 1, 16'hAAAA, 1000, 0, -1, 1'b0);
      chk("single_done_cyc", done_cyc, 3);
      chk("single_done_cnt", done_cnt, 1);
      post_idle(16'hAAAA, 16'd0);

      // Full depth: num_words=0 means 256 words
      run(8'hC0, 256, 16'h5555, 1000, 0, -1, 1'b0);
      chk("full_done_cyc", done_cyc, 258);
      chk("full_done_cnt", done_cnt, 1);
      post_idle(16'h5555, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tf_fetch_ctrl.md
TF_FETCH_CTRL -- requirements
Module: tf_fetch_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default `D_width, meaning the width of one twiddle factor and of the modulus.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the twiddle ROM address width.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-004 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse that begins a fetch run
- base_addr  in  ADDR_W  first ROM word of the run
- num_words  in  ADDR_W  number of words in the run; 0 means 2^ADDR_W
- modulus_in  in  D_WIDTH  modulus for the run
- rom_rd_en  out  1  ROM read strobe
- rom_rd_addr  out  ADDR_W  ROM address
- rom_rd_data  in  16*D_WIDTH  16 TFs per word; valid exactly 1 cycle after rom_rd_en
- tf_out  out  16*D_WIDTH  TF0 in bits [D_WIDTH-1:0] ... TF15 in the top slice; feeds the TF delay pipeline
- modulus_out  out  D_WIDTH  latched modulus
- tf_valid  out  1  tf_out holds a word
- tf_ready  in  1  the consumer accepts the word
- busy  out  1  a run is in progress
- done  out  1  one-cycle pulse after the last word is accepted

Function
REQ-005 SHALL implement the FSM IDLE -> FETCH -> DRAIN -> IDLE.
REQ-006 In IDLE, start SHALL latch base_addr, num_words and modulus_in, clear the issue and accept counters, and go to FETCH on the next cycle; start is ignored outside IDLE.
REQ-007 SHALL buffer output words in a 2-entry FIFO, with a ROM read issued only when (FIFO occupancy + reads in flight) < 2; no word is ever dropped or duplicated.
REQ-008 Each issued read SHALL set rom_rd_addr = base_addr + issue count, modulo 2^ADDR_W (wrap-around at the address limit is legal).
REQ-009 Returned rom_rd_data SHALL be written into the FIFO 1 cycle after its rom_rd_en.
REQ-010 tf_valid SHALL equal FIFO not empty, and tf_out SHALL be the FIFO head.
REQ-011 A transfer SHALL occur on any cycle with tf_valid and tf_ready both high.
REQ-012 tf_out SHALL stay stable while tf_valid is high and tf_ready is low.
REQ-013 A simultaneous FIFO write and pop SHALL keep occupancy unchanged.
REQ-014 FETCH SHALL go to DRAIN in the cycle the last read issues.
REQ-015 DRAIN SHALL go to IDLE, and assert done for 1 cycle, on the cycle the last word transfers.
REQ-016 busy SHALL be high in FETCH and DRAIN.
REQ-017 Latency SHALL be: start at cycle 0, first rom_rd_en at cycle 1, first tf_valid at cycle 3.
REQ-018 With tf_ready held high, throughput SHALL be 1 word per cycle after the first word.
REQ-019 modulus_out SHALL hold the latched value from start until the next accepted start.

Reset
REQ-020 Reset SHALL force IDLE; rom_rd_en, tf_valid, busy and done to 0; tf_out, modulus_out and rom_rd_addr to 0; FIFO and counters empty.
REQ-021 Reset asserted mid-run SHALL abort the run without a done pulse and discard any in-flight read data.
REQ-022 The first start SHALL be honoured in the cycle after rst deasserts.

Configuration
REQ-023 When macro TF_FETCH_STALL_CNT_EN is defined, the block SHALL add output stall_cnt (16 bits), which counts cycles with tf_valid high and tf_ready low, saturates at 0xFFFF, clears on accepted start and on reset, and holds after done.
REQ-024 When TF_FETCH_STALL_CNT_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-025 Basic run: base_addr=0x10, num_words=4, tf_ready=1 -> reads at 0x10..0x13 in cycles 1..4; tf_valid in cycles 3..6 with matching ROM words; done at cycle 6.
REQ-026 Wrap-around: base_addr=0xFE, num_words=4 (ADDR_W=8) -> addresses 0xFE, 0xFF, 0x00, 0x01, in order.
REQ-027 Backpressure: tf_ready low for 5 cycles mid-run -> at most 2 outstanding words, tf_out stable, no loss or duplication, stall_cnt=5 when enabled.
REQ-028 Ignored start: start during a busy run with different base_addr and modulus_in -> the run is unaffected and modulus_out is unchanged.
REQ-029 Reset mid-run: rst after 2 of 8 words -> next cycle tf_valid=0, busy=0, no done; a following run with num_words=1 completes normally.
REQ-030 Full depth: num_words=0 -> 256 words transfer, addresses wrap to base_addr, and done pulses once.
